// File: rtl/inv_srl_array_if.sv
// Port bundle for inv_srl_array: shift data/enables/flush/tap address in, tap data/valid/fill out.
// d, ce and flush carry invertible_pin attributes so inverters feeding them can be absorbed.
interface inv_srl_array_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1,
  parameter int ADDR_W   = 4
);
  (* invertible_pin = "INV_D" *)
  logic [CHANNELS*WIDTH-1:0]      d;
  (* invertible_pin = "INV_CE" *)
  logic [CHANNELS-1:0]            ce;
  (* invertible_pin = "INV_FLUSH" *)
  logic                           flush;
  logic [CHANNELS*ADDR_W-1:0]     addr;
  logic [CHANNELS*WIDTH-1:0]      q;
  logic [CHANNELS-1:0]            q_valid;
  logic [CHANNELS*(ADDR_W+1)-1:0] fill;

  modport master (output d, ce, flush, addr, input q, q_valid, fill);
  modport slave  (input d, ce, flush, addr, output q, q_valid, fill);
endinterface

// File: rtl/inv_srl_array.sv
// Bank of addressable shift-register delay lines with invertible d/ce/flush and per-channel fill tracking.
// Tap read is combinational (OUT_REG=0) or one registered cycle (OUT_REG=1); no backpressure, shifts on ce.
module inv_srl_array #(
  parameter int                        CHANNELS  = 2,
  parameter int                        WIDTH     = 1,
  parameter int                        DEPTH     = 16,
  parameter int                        ADDR_W    = $clog2(DEPTH),
  parameter logic [CHANNELS*WIDTH-1:0] INV_D     = '0,
  parameter logic [CHANNELS-1:0]       INV_CE    = '0,
  parameter logic                      INV_FLUSH = 1'b0,
  parameter bit                        OUT_REG   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  inv_srl_array_if.slave  bus
);

  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);
  localparam bit              POW2     = (DEPTH == (1 << ADDR_W));

  logic [CHANNELS*WIDTH-1:0] d_e;
  logic [CHANNELS-1:0]       ce_e;
  logic                      flush_e;

  assign d_e     = bus.d ^ INV_D;
  assign ce_e    = bus.ce ^ INV_CE;
  assign flush_e = bus.flush ^ INV_FLUSH;

  logic [WIDTH-1:0] stage     [CHANNELS][DEPTH];
  logic [WIDTH-1:0] stage_nxt [CHANNELS][DEPTH];
  logic [ADDR_W:0]  fill_r    [CHANNELS];
  logic [ADDR_W:0]  fill_nxt  [CHANNELS];

  // Next state is built explicitly so the registered tap can read post-edge contents.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      fill_nxt[c] = fill_r[c];
      for (int i = 0; i < DEPTH; i++) stage_nxt[c][i] = stage[c][i];
      if (flush_e) begin
        fill_nxt[c] = '0;
        for (int i = 0; i < DEPTH; i++) stage_nxt[c][i] = '0;
      end else if (ce_e[c]) begin
        stage_nxt[c][0] = d_e[c*WIDTH +: WIDTH];
        for (int i = 1; i < DEPTH; i++) stage_nxt[c][i] = stage[c][i-1];
        if (fill_r[c] != FILL_MAX) fill_nxt[c] = fill_r[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        fill_r[c] <= '0;
        for (int i = 0; i < DEPTH; i++) stage[c][i] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        fill_r[c] <= fill_nxt[c];
        for (int i = 0; i < DEPTH; i++) stage[c][i] <= stage_nxt[c][i];
      end
    end
  end

  logic [CHANNELS*WIDTH-1:0]      q_all;
  logic [CHANNELS-1:0]            qv_all;
  logic [CHANNELS*(ADDR_W+1)-1:0] fill_all;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ADDR_W-1:0] a;
    logic              in_rng;

    assign a = bus.addr[c*ADDR_W +: ADDR_W];
    assign fill_all[c*(ADDR_W+1) +: (ADDR_W+1)] = fill_r[c];

    // Only a non-power-of-2 depth has addresses past the last stage.
    if (POW2) begin : g_full
      assign in_rng = 1'b1;
    end else begin : g_part
      assign in_rng = ({1'b0, a} < FILL_MAX);
    end

    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] q_r;
      logic             qv_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_r  <= '0;
          qv_r <= 1'b0;
        end else begin
          q_r  <= in_rng ? stage_nxt[c][a] : '0;
          qv_r <= in_rng && (fill_nxt[c] > {1'b0, a});
        end
      end

      assign q_all[c*WIDTH +: WIDTH] = q_r;
      assign qv_all[c]               = qv_r;
    end else begin : g_comb
      assign q_all[c*WIDTH +: WIDTH] = in_rng ? stage[c][a] : '0;
      assign qv_all[c]               = in_rng && (fill_r[c] > {1'b0, a});
    end
  end

  assign bus.q       = q_all;
  assign bus.q_valid = qv_all;
  assign bus.fill    = fill_all;

endmodule
